// File: rtl/arr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arr_arb_pkg
// Description : Shared types, default widths and the round-robin pick helper
//               used by the array-port arbiter and its picker.
// Revision    : 1.0 - initial release
// ============================================================================
package arr_arb_pkg;

    localparam int C_NREQ_DEF     = 2;
    localparam int C_ADDR_W_DEF   = 1;
    localparam int C_DATA_W_DEF   = 64;
    localparam int C_LOCK_MAX_DEF = 4;

    // Upper bound on the requester count handled by rr_pick; the vector
    // arguments are sized to this so one function serves any NREQ.
    localparam int C_MAX_REQ = 32;
    localparam int C_IDX_W   = 5;

    typedef enum logic [0:0] {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    // One-hot pick of the first asserted request at or above ptr, wrapping
    // from n-1 back to 0. Returns zero when no request is asserted.
    function automatic logic [C_MAX_REQ-1:0] rr_pick(
        input logic [C_MAX_REQ-1:0] req,
        input int                   ptr,
        input int                   n
    );
        logic [C_MAX_REQ-1:0] v_gnt;
        logic                 v_found;
        int                   v_idx;
        v_gnt   = '0;
        v_found = 1'b0;
        v_idx   = 0;
        for (int k = 0; k < C_MAX_REQ; k++) begin
            if (k < n && !v_found) begin
                v_idx = (ptr + k) % n;
                if (req[v_idx[C_IDX_W-1:0]]) begin
                    v_gnt[v_idx[C_IDX_W-1:0]] = 1'b1;
                    v_found                   = 1'b1;
                end
            end
        end
        return v_gnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arr_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational one-hot round-robin pick from a request vector
//               and a priority pointer.
// Ports       : req - request vector, ptr - highest-priority index,
//               gnt - one-hot pick (zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import arr_arb_pkg::*;
#(
    parameter int NREQ  = C_NREQ_DEF,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    assign gnt = NREQ'(rr_pick(C_MAX_REQ'(req), 32'(ptr), NREQ));

endmodule
`default_nettype wire

// File: rtl/arr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : arr_port_arbiter
// Description : Round-robin arbiter sharing one single-port synchronous array
//               (1-cycle read latency) among NREQ requesters. At most one
//               access is granted per cycle; read data returns one cycle after
//               the grant together with a per-requester valid strobe.
// Config      : define ARB_LOCK_EN to let a requester hold the port for up to
//               LOCK_MAX consecutive grants via req_lock.
// Ports       : clk, rst_n (synchronous, active-low)
//               req/req_we/req_lock  per-requester request, write, lock
//               req_addr/req_wdata   packed per-requester address and data
//               gnt                  one-hot grant (combinational)
//               rvalid/rdata         read return, one cycle after read grant
//               mem_we/mem_addr/mem_wdata/mem_rdata  array port
// Revision    : 1.0 - initial release
// ============================================================================
module arr_port_arbiter
    import arr_arb_pkg::*;
#(
    parameter int NREQ     = C_NREQ_DEF,
    parameter int ADDR_W   = C_ADDR_W_DEF,
    parameter int DATA_W   = C_DATA_W_DEF,
    parameter int LOCK_MAX = C_LOCK_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    input  logic [NREQ-1:0]          req_lock,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int                 C_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [C_PTR_W-1:0] C_LAST  = C_PTR_W'(NREQ - 1);

    logic [C_PTR_W-1:0] r_rr_ptr;
    logic [C_PTR_W-1:0] w_rr_ptr_nxt;
    logic [NREQ-1:0]    w_pick;
    logic [C_PTR_W-1:0] w_pick_idx;
    logic               w_pick_any;
    logic [NREQ-1:0]    w_gnt;
    logic [NREQ-1:0]    r_rvalid;

    function automatic logic [C_PTR_W-1:0] f_next_ptr(input logic [C_PTR_W-1:0] idx);
        return (idx == C_LAST) ? '0 : idx + C_PTR_W'(1);
    endfunction

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (C_PTR_W)
    ) u_rr_picker (
        .req (req),
        .ptr (r_rr_ptr),
        .gnt (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) w_pick_idx = C_PTR_W'(i);
        end
    end

    assign w_pick_any = |w_pick;

`ifdef ARB_LOCK_EN
    localparam int C_CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [C_PTR_W-1:0] r_owner;
    logic [C_PTR_W-1:0] w_owner_nxt;
    logic [C_CNT_W-1:0] r_lock_cnt;
    logic [C_CNT_W-1:0] w_lock_cnt_nxt;
    logic [NREQ-1:0]    w_owner_oh;

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    always_comb begin
        w_gnt          = '0;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        if (rst_n) begin
            case (r_state)
                ARB_UNLOCKED: begin
                    if (w_pick_any) begin
                        w_gnt        = w_pick;
                        w_rr_ptr_nxt = f_next_ptr(w_pick_idx);
                        // With LOCK_MAX of 1 the first grant is already the
                        // last one, so the lock is never entered.
                        if (req_lock[w_pick_idx] && (LOCK_MAX > 1)) begin
                            w_state_nxt    = ARB_LOCKED;
                            w_owner_nxt    = w_pick_idx;
                            w_lock_cnt_nxt = C_CNT_W'(1);
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (req[r_owner]) begin
                        w_gnt          = w_owner_oh;
                        w_rr_ptr_nxt   = f_next_ptr(r_owner);
                        w_lock_cnt_nxt = r_lock_cnt + C_CNT_W'(1);
                        // This grant is the last one when the owner releases
                        // the lock or the hold budget is used up.
                        if (!req_lock[r_owner] ||
                            (r_lock_cnt + C_CNT_W'(1) == C_CNT_W'(LOCK_MAX))) begin
                            w_state_nxt    = ARB_UNLOCKED;
                            w_lock_cnt_nxt = '0;
                        end
                    end else begin
                        w_state_nxt    = ARB_UNLOCKED;
                        w_lock_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt    = ARB_UNLOCKED;
                    w_lock_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ARB_UNLOCKED;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end
`else
    logic w_unused_lock;

    always_comb begin
        w_gnt        = '0;
        w_rr_ptr_nxt = r_rr_ptr;
        if (rst_n && w_pick_any) begin
            w_gnt        = w_pick;
            w_rr_ptr_nxt = f_next_ptr(w_pick_idx);
        end
    end

    assign w_unused_lock = (^req_lock) ^ (LOCK_MAX > 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_rvalid <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
            r_rvalid <= w_gnt & ~req_we;
        end
    end

    // AND-OR mux: with a one-hot (or zero) grant only the granted slice can
    // reach the array port, and an idle cycle drives all zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            mem_we    = mem_we | (w_gnt[i] & req_we[i]);
            mem_addr  = mem_addr  | (req_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{w_gnt[i]}});
            mem_wdata = mem_wdata | (req_wdata[i*DATA_W +: DATA_W] & {DATA_W{w_gnt[i]}});
        end
    end

    assign gnt    = w_gnt;
    assign rvalid = r_rvalid;
    assign rdata  = mem_rdata;

endmodule
`default_nettype wire
